// File: rtl/nfca_sched_pkg.sv
// Shared types and default timing for the NFC-A transaction scheduler.
// Cycle counts assume the 81.36 MHz system clock.
package nfca_sched_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    GUARD = 3'd1,
    ARB   = 3'd2,
    TX    = 3'd3,
    RX    = 3'd4
  } sched_state_t;

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_POLL = 1'b1
  } sched_src_t;

  localparam int DEF_CNT_W           = 26;
  localparam int DEF_GUARD_CYC       = 406800;    // 5 ms carrier settle
  localparam int DEF_RX_TIMEOUT_CYC  = 81360;     // 1 ms PICC response window
  localparam int DEF_POLL_PERIOD_CYC = 8136000;   // 100 ms REQA interval
  localparam int DEF_IDLE_OFF_CYC    = 40680000;  // 500 ms idle before field off
  localparam int DEF_TX_WDOG_CYC     = 1627200;   // 20 ms tx_done watchdog

  // Arbitration: a lone requester always wins; on a tie the source that
  // did not go last is served, so host and poller alternate.
  function automatic sched_src_t pick_src(input logic host_pend,
                                          input logic poll_pend,
                                          input sched_src_t last);
    if (host_pend && poll_pend) return (last == SRC_HOST) ? SRC_POLL : SRC_HOST;
    else if (poll_pend)         return SRC_POLL;
    else                        return SRC_HOST;
  endfunction

endpackage

// File: rtl/nfca_sched_timer.sv
// Loadable down-counter. A load of N raises expire during the Nth cycle
// after the load, so a consumer acting on expire reacts exactly N clocks
// after it loaded. Once it reaches zero the counter parks there.
module nfca_sched_timer
  import nfca_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/nfca_txn_scheduler.sv
// NFC-A field sequencer and TX/RX arbiter between host UART frames and the
// autonomous REQA poller.
// Optional build macro NFCA_SCHED_WATCHDOG_EN: aborts a transaction whose
// tx_done never arrives, pulsing sched_err and dropping the carrier.
module nfca_txn_scheduler
  import nfca_sched_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int GUARD_CYC       = DEF_GUARD_CYC,
  parameter int RX_TIMEOUT_CYC  = DEF_RX_TIMEOUT_CYC,
  parameter int POLL_PERIOD_CYC = DEF_POLL_PERIOD_CYC,
  parameter int IDLE_OFF_CYC    = DEF_IDLE_OFF_CYC,
  parameter int TX_WDOG_CYC     = DEF_TX_WDOG_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       host_req,
  output logic       host_ack,
  output logic       host_timeout,
  input  logic       poll_en,
  output logic       tag_present,
  output logic       carrier_on,
  output logic       tx_start,
  output logic       tx_src,
  input  logic       tx_done,
  input  logic       rx_valid,
  output logic       sched_err,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] RXTO_V  = CNT_W'(RX_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] POLL_V  = CNT_W'(POLL_PERIOD_CYC);
  localparam logic [CNT_W-1:0] IDLE_V  = CNT_W'(IDLE_OFF_CYC);
  localparam logic [CNT_W-1:0] WDOG_V  = CNT_W'(TX_WDOG_CYC);

  sched_state_t     state;
  sched_src_t       last_src;
  sched_src_t       grant_src;
  logic             poll_due;
  logic             pend_any;
  logic             grant_poll;
  logic             fsm_load;
  logic [CNT_W-1:0] fsm_val;
  logic             fsm_expire;
  logic             poll_load;
  logic             poll_expire;
  logic             wdog_abort;

  assign pend_any   = host_req | poll_due;
  assign grant_src  = pick_src(host_req, poll_due, last_src);
  assign grant_poll = (state == ARB) && pend_any && (grant_src == SRC_POLL);
  assign state_dbg  = state;

`ifdef NFCA_SCHED_WATCHDOG_EN
  assign wdog_abort = (state == TX) && !tx_done && fsm_expire;
`else
  assign wdog_abort = 1'b0;
`endif

  // The single FSM timer is reloaded on every state transition that needs a
  // fresh window. The watchdog window is armed on every grant; a build
  // without the watchdog simply never looks at the expiry while in TX.
  always_comb begin
    fsm_load = 1'b0;
    fsm_val  = '0;
    case (state)
      OFF:   if (pend_any)              begin fsm_load = 1'b1; fsm_val = GUARD_V; end
      GUARD: if (fsm_expire)            begin fsm_load = 1'b1; fsm_val = IDLE_V;  end
      ARB:   if (pend_any)              begin fsm_load = 1'b1; fsm_val = WDOG_V;  end
      TX:    if (tx_done)               begin fsm_load = 1'b1; fsm_val = RXTO_V;  end
      RX:    if (rx_valid || fsm_expire) begin fsm_load = 1'b1; fsm_val = IDLE_V;  end
      default: ;
    endcase
  end

  nfca_sched_timer #(.CNT_W(CNT_W)) u_fsm_tmr (
    .clk    (clk),
    .rstn   (rstn),
    .en     (1'b1),
    .load   (fsm_load),
    .value  (fsm_val),
    .expire (fsm_expire)
  );

  // The poll timer free-runs while polling is enabled and is held at a full
  // period while disabled, so re-enabling always starts a fresh interval.
  assign poll_load = !poll_en || poll_expire;

  nfca_sched_timer #(.CNT_W(CNT_W)) u_poll_tmr (
    .clk    (clk),
    .rstn   (rstn),
    .en     (poll_en),
    .load   (poll_load),
    .value  (POLL_V),
    .expire (poll_expire)
  );

  // Sticky poll request: a new expiry wins over a grant in the same cycle so
  // an interval that elapsed is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      poll_due <= 1'b0;
    end else if (!poll_en) begin
      poll_due <= 1'b0;
    end else if (poll_expire) begin
      poll_due <= 1'b1;
    end else if (grant_poll) begin
      poll_due <= 1'b0;
    end
  end

  // Main sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= OFF;
      last_src     <= SRC_POLL;
      carrier_on   <= 1'b0;
      tx_start     <= 1'b0;
      tx_src       <= 1'b0;
      host_ack     <= 1'b0;
      host_timeout <= 1'b0;
      tag_present  <= 1'b0;
      sched_err    <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      host_ack     <= 1'b0;
      host_timeout <= 1'b0;
      sched_err    <= 1'b0;
      case (state)
        OFF: begin
          carrier_on <= 1'b0;
          if (pend_any) begin
            carrier_on <= 1'b1;
            state      <= GUARD;
          end
        end
        GUARD: begin
          if (fsm_expire) state <= ARB;
        end
        ARB: begin
          if (pend_any) begin
            tx_start <= 1'b1;
            tx_src   <= grant_src;
            last_src <= grant_src;
            state    <= TX;
          end else if (fsm_expire) begin
            carrier_on <= 1'b0;
            state      <= OFF;
          end
        end
        TX: begin
          if (tx_done) begin
            state <= RX;
          end else if (wdog_abort) begin
            sched_err  <= 1'b1;
            carrier_on <= 1'b0;
            state      <= OFF;
            if (tx_src == SRC_HOST) begin
              host_ack     <= 1'b1;
              host_timeout <= 1'b1;
            end
          end
        end
        RX: begin
          if (rx_valid || fsm_expire) begin
            state <= ARB;
            if (tx_src == SRC_HOST) begin
              host_ack     <= 1'b1;
              host_timeout <= !rx_valid;
            end else begin
              tag_present <= rx_valid;
            end
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_nfca_txn_scheduler.sv
// Scoreboard bench for nfca_txn_scheduler with shortened timing.
// Grants and transaction results are queued as stimulus is driven and
// checked by a negedge monitor when the DUT reports them.
module tb_nfca_txn_scheduler;
  import nfca_sched_pkg::*;

  localparam int GUARD_CYC       = 10;
  localparam int RX_TIMEOUT_CYC  = 20;
  localparam int POLL_PERIOD_CYC = 100;
  localparam int IDLE_OFF_CYC    = 50;
  localparam int TX_WDOG_CYC     = 30;

  typedef struct {
    logic src;
    logic flag;
  } res_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       host_req = 1'b0;
  logic       poll_en = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic       host_ack, host_timeout, tag_present, carrier_on;
  logic       tx_start, tx_src, sched_err;
  logic [2:0] state_dbg;

  logic       grantQ[$];
  res_t       resultQ[$];
  res_t       monRes;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [2:0] prevState = 3'd0;

  nfca_txn_scheduler #(
    .CNT_W           (26),
    .GUARD_CYC       (GUARD_CYC),
    .RX_TIMEOUT_CYC  (RX_TIMEOUT_CYC),
    .POLL_PERIOD_CYC (POLL_PERIOD_CYC),
    .IDLE_OFF_CYC    (IDLE_OFF_CYC),
    .TX_WDOG_CYC     (TX_WDOG_CYC)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .host_req     (host_req),
    .host_ack     (host_ack),
    .host_timeout (host_timeout),
    .poll_en      (poll_en),
    .tag_present  (tag_present),
    .carrier_on   (carrier_on),
    .tx_start     (tx_start),
    .tx_src       (tx_src),
    .tx_done      (tx_done),
    .rx_valid     (rx_valid),
    .sched_err    (sched_err),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One-cycle pulse on the TX/RX core handshakes, sampled at the next edge.
  task automatic applyStimulus(input logic td, input logic rv);
    tx_done  = td;
    rx_valid = rv;
    @(posedge clk); #1;
    tx_done  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic waitCarrier(input logic level, input int limit, output int c);
    int n = 0;
    while (carrier_on !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(level ? "carrier_rise" : "carrier_fall", carrier_on, level);
    c = cyc;
  endtask

  task automatic startTxn(input logic expSrc, output int startCyc);
    int n = 0;
    grantQ.push_back(expSrc);
    while (!tx_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_start_seen", tx_start, 1);
    startCyc = cyc;
  endtask

  // Ends the PCD frame, optionally answers rxDelay cycles later, and waits
  // for the return to ARB. lat counts edges from tx_done sample to completion.
  task automatic finishTxn(input logic expSrc, input bit respond, input int rxDelay,
                           input bit dropHost, output int lat);
    int   n = 0;
    int   doneCyc;
    res_t r;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0);
    doneCyc = cyc;
    r.src  = expSrc;
    r.flag = (expSrc == SRC_HOST) ? !respond : respond;
    resultQ.push_back(r);
    if (respond) begin
      repeat (rxDelay - 1) begin @(posedge clk); #1; end
      applyStimulus(1'b0, 1'b1);
    end
    while (state_dbg != ARB && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txn_done_state", state_dbg, ARB);
    if (expSrc == SRC_HOST) checkOutput("host_ack_seen", host_ack, 1);
    if (dropHost) host_req = 1'b0;
    lat = cyc - doneCyc;
  endtask

  // Scoreboard monitor: grants on tx_start, host results on host_ack,
  // poll results on an RX-to-ARB return without host_ack.
  always @(negedge clk) begin
    if (rstn) begin
      if (tx_start) begin
        checkOutput("grant_pending", grantQ.size() > 0, 1);
        if (grantQ.size() > 0) checkOutput("tx_src", tx_src, grantQ.pop_front());
      end
      if (host_ack) begin
        checkOutput("ack_pending", resultQ.size() > 0, 1);
        if (resultQ.size() > 0) begin
          monRes = resultQ.pop_front();
          checkOutput("ack_src", tx_src, monRes.src);
          checkOutput("host_timeout", host_timeout, monRes.flag);
        end
      end else if (prevState == RX && state_dbg == ARB) begin
        checkOutput("poll_pending", resultQ.size() > 0, 1);
        if (resultQ.size() > 0) begin
          monRes = resultQ.pop_front();
          checkOutput("poll_src", tx_src, monRes.src);
          checkOutput("tag_present", tag_present, monRes.flag);
        end
      end
    end
    prevState = state_dbg;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int c0, c1, lat;
    res_t wr;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_host_ack", host_ack, 0);
    checkOutput("rst_host_timeout", host_timeout, 0);
    checkOutput("rst_tag_present", tag_present, 0);
    checkOutput("rst_carrier_on", carrier_on, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_src", tx_src, 0);
    checkOutput("rst_sched_err", sched_err, 0);
    checkOutput("rst_state", state_dbg, OFF);
    rstn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("idle_state", state_dbg, OFF);

    // Host single transaction with a response, then idle carrier-off
    $display("[TB] host single transaction");
    host_req = 1'b1;
    waitCarrier(1'b1, 20, c0);
    startTxn(SRC_HOST, c1);
    checkOutput("guard_to_tx_start", c1 - c0, GUARD_CYC + 1);
    finishTxn(SRC_HOST, 1'b1, 8, 1'b1, lat);
    checkOutput("rx_latency", lat, 8);
    c0 = cyc;
    waitCarrier(1'b0, 100, c1);
    checkOutput("idle_off_cycles", c1 - c0, IDLE_OFF_CYC);
    checkOutput("idle_off_state", state_dbg, OFF);

    // Host transaction without PICC response
    $display("[TB] host timeout");
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    finishTxn(SRC_HOST, 1'b0, 0, 1'b1, lat);
    checkOutput("timeout_latency", lat, RX_TIMEOUT_CYC);

    // Two polls: one answered, one silent
    $display("[TB] polling");
    poll_en = 1'b1;
    startTxn(SRC_POLL, c1);
    finishTxn(SRC_POLL, 1'b1, 5, 1'b0, lat);
    checkOutput("tag_after_hit", tag_present, 1);
    startTxn(SRC_POLL, c1);
    finishTxn(SRC_POLL, 1'b0, 0, 1'b0, lat);
    checkOutput("tag_after_miss", tag_present, 0);
    poll_en = 1'b0;

    // Contention: poll wakes the field, host joins during the guard time
    $display("[TB] contention");
    waitCarrier(1'b0, 100, c0);
    poll_en = 1'b1;
    waitCarrier(1'b1, 300, c0);
    checkOutput("contention_guard", state_dbg, GUARD);
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    finishTxn(SRC_HOST, 1'b1, 6, 1'b0, lat);
    startTxn(SRC_POLL, c1);
    finishTxn(SRC_POLL, 1'b1, 6, 1'b0, lat);
    startTxn(SRC_HOST, c1);
    finishTxn(SRC_HOST, 1'b1, 6, 1'b1, lat);
    poll_en = 1'b0;

    // rx_valid on the same edge the response window closes
    $display("[TB] simultaneous rx_valid and timeout");
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    finishTxn(SRC_HOST, 1'b1, RX_TIMEOUT_CYC, 1'b1, lat);
    checkOutput("edge_latency", lat, RX_TIMEOUT_CYC);

    // Stray handshakes while idle in ARB
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("stray_tx_done_state", state_dbg, ARB);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stray_rx_valid_state", state_dbg, ARB);

    // Asynchronous reset while waiting for a PICC frame
    $display("[TB] reset mid-RX");
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("pre_reset_state", state_dbg, RX);
    checkOutput("pre_reset_carrier", carrier_on, 1);
    #2;
    rstn = 1'b0;
    host_req = 1'b0;
    #1;
    checkOutput("mid_rst_carrier_on", carrier_on, 0);
    checkOutput("mid_rst_tx_src", tx_src, 0);
    checkOutput("mid_rst_host_ack", host_ack, 0);
    checkOutput("mid_rst_state", state_dbg, OFF);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

`ifdef NFCA_SCHED_WATCHDOG_EN
    // Withheld tx_done: watchdog aborts the host transaction
    $display("[TB] watchdog abort");
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    wr.src  = SRC_HOST;
    wr.flag = 1'b1;
    resultQ.push_back(wr);
    c0 = 0;
    while (!sched_err && c0 < 100) begin
      @(negedge clk);
      c0++;
    end
    checkOutput("sched_err_seen", sched_err, 1);
    host_req = 1'b0;
    checkOutput("wdog_latency", cyc - c1, TX_WDOG_CYC);
    checkOutput("wdog_carrier", carrier_on, 0);
    checkOutput("wdog_state", state_dbg, OFF);
`else
    // Withheld tx_done: without the watchdog TX waits indefinitely
    $display("[TB] no watchdog: TX holds");
    host_req = 1'b1;
    startTxn(SRC_HOST, c1);
    repeat (TX_WDOG_CYC + 10) @(negedge clk);
    checkOutput("no_wdog_state", state_dbg, TX);
    checkOutput("no_wdog_sched_err", sched_err, 0);
    checkOutput("no_wdog_carrier", carrier_on, 1);
    finishTxn(SRC_HOST, 1'b1, 5, 1'b1, lat);
    wr.src  = tx_src;
    wr.flag = sched_err;
    checkOutput("no_wdog_err_after", wr.flag, 0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("grant_q_empty", grantQ.size(), 0);
    checkOutput("result_q_empty", resultQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfca_txn_scheduler.md
Name: nfca_txn_scheduler

Overview:
- Sequences the NFC-A field and shares the PCD transmit/receive datapath between two requesters: host UART frames and an autonomous REQA poller.
- Switches the carrier on with a guard time and arbitrates each transaction.
- Enforces a PICC response timeout, then switches the field off after an idle period.
- Sits inside the UART-to-NFCA system, between the UART command path and the NFC-A TX/RX cores, in the 81.36 MHz domain.

Parameters:
- GUARD_CYC, 406800: carrier-on settle time before first TX (5 ms).
- RX_TIMEOUT_CYC, 81360: max wait for PICC frame after tx_done (1 ms).
- POLL_PERIOD_CYC, 8136000: poll request interval (100 ms).
- IDLE_OFF_CYC, 40680000: idle time in ARB before carrier off (500 ms).
- TX_WDOG_CYC, 1627200: tx_done watchdog (20 ms; used only with the macro).
- CNT_W, 26: timer width; every *_CYC must be < 2^CNT_W.

Ports:
- clk  in  1  81.36 MHz system clock
- rstn  in  1  asynchronous active-low reset
- host_req  in  1  host frame pending; level, held until host_ack
- host_ack  out  1  1-cycle pulse: host transaction finished
- host_timeout  out  1  valid with host_ack; 1 = no PICC response
- poll_en  in  1  enable autonomous polling
- tag_present  out  1  result of last completed poll
- carrier_on  out  1  carrier enable to carrier generator
- tx_start  out  1  1-cycle pulse to NFC-A TX core
- tx_src  out  1  0 = host frame, 1 = REQA; stable from tx_start to end of RX
- tx_done  in  1  pulse from TX core, end of PCD frame
- rx_valid  in  1  pulse from RX core, end of PICC frame
- sched_err  out  1  1-cycle pulse on watchdog abort (0 without the macro)
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset values: all outputs 0; FSM in OFF; last_src = 1, so the host wins the first tie.
- Poll timer:
  - Runs while poll_en = 1.
  - On expiry it sets sticky poll_due and reloads.
  - poll_en = 0 clears poll_due and reloads the timer.
- OFF:
  - carrier_on = 0.
  - host_req or poll_due -> GUARD; carrier_on = 1 from the next cycle; load GUARD_CYC.
- GUARD: timer reaches 0 -> ARB.
- ARB:
  - Load IDLE_OFF_CYC on entry.
  - Host only -> grant host. Poll only -> grant poll. Both pending -> grant the opposite of last_src.
  - On grant: pulse tx_start, latch tx_src and last_src, clear poll_due if poll granted, go to TX.
  - Idle timer expires with nothing pending -> OFF.
- TX: tx_done -> RX; load RX_TIMEOUT_CYC.
- RX:
  - rx_valid -> success. Timer expiry -> timeout. Both in the same cycle -> success.
  - Host transaction: host_ack pulse, host_timeout = timeout.
  - Poll transaction: tag_present <= success.
  - Then -> ARB.
- Ignored events: tx_done outside TX; rx_valid outside RX.
- Mid-transaction changes:
  - host_req dropped mid-transaction: the transaction still completes and host_ack still pulses.
  - poll_en dropped mid-poll: the poll completes and tag_present updates.
- Latency: tx_start asserts 1 cycle after entering ARB with a request pending.
- Timer semantics: a load of N expires N cycles later.
- No request queueing beyond one host level and one sticky poll_due.

Optional Feature:
- Macro: NFCA_SCHED_WATCHDOG_EN.
- When defined:
  - TX loads TX_WDOG_CYC on entry.
  - Expiry before tx_done -> pulse sched_err, carrier off, go to OFF.
  - If the aborted transaction was a host transaction, also pulse host_ack with host_timeout = 1.
- When undefined: TX waits indefinitely for tx_done and sched_err is tied 0.

Decomposition:
- Package nfca_sched_pkg: FSM state enum (OFF, GUARD, ARB, TX, RX), source enum (SRC_HOST, SRC_POLL), default cycle constants.
- Sub-module nfca_sched_timer: loadable CNT_W down-counter with load, value and expire; instantiated twice (FSM timer, poll timer).

Test Plan:
All scenarios use GUARD_CYC = 10, RX_TIMEOUT_CYC = 20, POLL_PERIOD_CYC = 100, IDLE_OFF_CYC = 50, TX_WDOG_CYC = 30.
- Host single transaction: host_req at cycle 5 -> carrier_on high, tx_start 11 cycles later with tx_src = 0; after tx_done, rx_valid 8 cycles later -> host_ack = 1, host_timeout = 0. After 50 idle cycles carrier_on = 0.
- Host timeout: no rx_valid after tx_done -> host_ack and host_timeout pulse exactly 20 cycles after tx_done.
- Poll: poll_en = 1, rx_valid returned -> tag_present = 1. Next poll without response -> tag_present = 0.
- Contention: host_req held and poll_due set together in ARB -> grants alternate host, poll, host across three transactions.
- Simultaneous edge: rx_valid in the same cycle the RX timer expires -> success (host_timeout = 0). Stray tx_done/rx_valid in ARB -> no state change.
- Reset mid-RX: rstn low -> all outputs 0 immediately, FSM in OFF. With NFCA_SCHED_WATCHDOG_EN, withholding tx_done -> sched_err pulse 30 cycles after tx_start and carrier_on = 0.
